// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings and the fetch-stage state type.
package isa_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_MV   = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_SD   = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_MVNZ = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_LD   = 4'b0011;
    localparam logic [OPC_W-1:0] OPC_MVI  = 4'b0100;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'b0110;
    localparam logic [OPC_W-1:0] OPC_OR   = 4'b0111;
    localparam logic [OPC_W-1:0] OPC_SLT  = 4'b1000;
    localparam logic [OPC_W-1:0] OPC_SLL  = 4'b1001;
    localparam logic [OPC_W-1:0] OPC_SRL  = 4'b1010;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_mvi(input logic [OPC_W-1:0] opc);
        return opc == OPC_MVI;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: walks the PC through the translation table, pairs MVI with its
// immediate word and hands one instruction per valid/ready handshake downstream.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int PROG_LEN = 38
) (
    input  logic              Clock,
    input  logic              Resetn,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic [DATA_W-1:0] fetch_data,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] imm,
    output logic              has_imm,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    // One extra bit so PROG_LEN == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] PROG_END = (ADDR_W + 1)'(PROG_LEN);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] imm_q;
    logic              has_imm_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              valid_q;
    logic              halted_q;

    logic [ADDR_W-1:0] pc_d;
    logic              pc_end;
    logic              fetch_is_mvi;

    always_comb begin
        pc_d         = pc_q + 1'b1;
        pc_end       = {1'b0, pc_q} >= PROG_END;
        fetch_is_mvi = is_mvi(fetch_data[DATA_W-1 -: OPC_W]);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            instr_q    <= '0;
            imm_q      <= '0;
            has_imm_q  <= 1'b0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else if (redirect) begin
            // Any handshake in this cycle is treated as done; a pending MVI is dropped.
            pc_q     <= redirect_pc;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (pc_end) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        instr_q    <= fetch_data;
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_d;
                        if (fetch_is_mvi) begin
                            state_q <= S_IMM;
                        end else begin
                            imm_q     <= '0;
                            has_imm_q <= 1'b0;
                            valid_q   <= 1'b1;
                            state_q   <= S_HOLD;
                        end
                    end
                end
                S_IMM: begin
                    // MVI in the last mapped word has no immediate to read.
                    if (pc_end) begin
                        imm_q     <= '0;
                        has_imm_q <= 1'b0;
                    end else begin
                        imm_q     <= fetch_data;
                        has_imm_q <= 1'b1;
                        pc_q      <= pc_d;
                    end
                    valid_q <= 1'b1;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign fetch_addr  = pc_q;
    assign instr       = instr_q;
    assign imm         = imm_q;
    assign has_imm     = has_imm_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; a behavioural table stands in for the tlb.
module tb_instr_fetch;

    logic        Clock;
    logic        Resetn;
    logic [5:0]  fetch_addr;
    logic [15:0] fetch_data;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has_imm;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic        halted;

    logic [5:0]  fetch_addr2;
    logic [15:0] fetch_data2;
    logic [15:0] instr2;
    logic [15:0] imm2;
    logic        has_imm2;
    logic [5:0]  instr_pc2;
    logic        instr_valid2;
    logic        redirect2;
    logic [5:0]  redirect_pc2;
    logic        halted2;

    logic [15:0] rom [0:63];

    int total = 0;
    int bad   = 0;

    assign fetch_data  = rom[fetch_addr];
    assign fetch_data2 = rom[fetch_addr2];

    instr_fetch #(.ADDR_W(6), .DATA_W(16), .PROG_LEN(38)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .instr       (instr),
        .imm         (imm),
        .has_imm     (has_imm),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    // Short program: the MVI at word 10 is the last mapped word.
    instr_fetch #(.ADDR_W(6), .DATA_W(16), .PROG_LEN(11)) dut_short (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .fetch_addr  (fetch_addr2),
        .fetch_data  (fetch_data2),
        .instr       (instr2),
        .imm         (imm2),
        .has_imm     (has_imm2),
        .instr_pc    (instr_pc2),
        .instr_valid (instr_valid2),
        .instr_ready (1'b1),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .halted      (halted2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [15:0] last_instr;
        logic [5:0]  last_pc;
        int          delivered;
        int          budget;

        for (int unsigned i = 0; i < 64; i++) rom[i] = 16'hFFFF;
        rom[0]  = 16'h4000; rom[1]  = 16'h0002;
        rom[2]  = 16'h4200; rom[3]  = 16'h0003;
        rom[4]  = 16'h5200; rom[5]  = 16'h0040;
        rom[6]  = 16'h4400; rom[7]  = 16'h0009;
        rom[8]  = 16'h0683; rom[9]  = 16'h3000;
        rom[10] = 16'h4600; rom[11] = 16'h0007;
        for (int unsigned i = 12; i < 37; i++) rom[i] = 16'h1000 + 16'(i);
        rom[37] = 16'h5040;

        Resetn       = 1'b0;
        instr_ready  = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        redirect2    = 1'b0;
        redirect_pc2 = '0;

        repeat (2) @(posedge Clock);
        #1;
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_instr",  32'(instr),       32'h0);
        check("rst_imm",    32'(imm),         32'h0);
        check("rst_hasimm", 32'(has_imm),     32'd0);
        check("rst_ipc",    32'(instr_pc),    32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_faddr",  32'(fetch_addr),  32'd0);
        Resetn = 1'b1;

        // MVI at 0 is delivered two edges after reset release
        step();
        check("t1_lat_valid", 32'(instr_valid), 32'd0);
        step();
        check("t1_valid",  32'(instr_valid), 32'd1);
        check("t1_instr",  32'(instr),       32'h4000);
        check("t1_imm",    32'(imm),         32'h0002);
        check("t1_hasimm", 32'(has_imm),     32'd1);
        check("t1_ipc",    32'(instr_pc),    32'd0);

        step();
        check("t2_bubble", 32'(instr_valid), 32'd0);
        step(); step();
        check("t2a_instr",  32'(instr),       32'h4200);
        check("t2a_imm",    32'(imm),         32'h0003);
        check("t2a_ipc",    32'(instr_pc),    32'd2);
        check("t2a_valid",  32'(instr_valid), 32'd1);
        step(); step();
        check("t2b_instr",  32'(instr),       32'h5200);
        check("t2b_imm",    32'(imm),         32'h0);
        check("t2b_hasimm", 32'(has_imm),     32'd0);
        check("t2b_ipc",    32'(instr_pc),    32'd4);
        check("t2b_valid",  32'(instr_valid), 32'd1);

        // backpressure
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_hold_valid", 32'(instr_valid), 32'd1);
            check("t3_hold_instr", 32'(instr),       32'h5200);
            check("t3_hold_faddr", 32'(fetch_addr),  32'd5);
        end
        instr_ready = 1'b1;
        step();
        check("t3_accept_valid", 32'(instr_valid), 32'd0);
        step();
        check("t3_next_instr", 32'(instr),    32'h0040);
        check("t3_next_ipc",   32'(instr_pc), 32'd5);
        step();
        step();
        check("t4_in_imm_valid", 32'(instr_valid), 32'd0);
        check("t4_in_imm_faddr", 32'(fetch_addr),  32'd7);

        // redirect while MVI waits for its immediate
        redirect    = 1'b1;
        redirect_pc = 6'd8;
        step();
        redirect = 1'b0;
        check("t4_redir_faddr", 32'(fetch_addr),  32'd8);
        check("t4_redir_valid", 32'(instr_valid), 32'd0);
        step();
        check("t4_instr",  32'(instr),       32'h0683);
        check("t4_ipc",    32'(instr_pc),    32'd8);
        check("t4_valid",  32'(instr_valid), 32'd1);
        check("t4_hasimm", 32'(has_imm),     32'd0);

        // redirect coinciding with a handshake, target beyond the program
        redirect    = 1'b1;
        redirect_pc = 6'd40;
        step();
        redirect = 1'b0;
        check("t4b_valid",  32'(instr_valid), 32'd0);
        check("t4b_faddr",  32'(fetch_addr),  32'd40);
        check("t4b_halted", 32'(halted),      32'd0);
        step();
        check("t4b_halt_next", 32'(halted),      32'd1);
        check("t4b_halt_vld",  32'(instr_valid), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 6'd9;
        step();
        redirect = 1'b0;
        check("t4b_unhalt", 32'(halted), 32'd0);

        // run to end of program
        last_instr = '0;
        last_pc    = '0;
        delivered  = 0;
        budget     = 200;
        while (!halted && budget > 0) begin
            step();
            budget--;
            if (instr_valid) begin
                last_instr = instr;
                last_pc    = instr_pc;
                delivered++;
            end
        end
        check("t5_halted",    32'(halted),      32'd1);
        check("t5_last_inst", 32'(last_instr),  32'h5040);
        check("t5_last_pc",   32'(last_pc),     32'd37);
        check("t5_count",     32'(delivered),   32'd28);
        check("t5_valid",     32'(instr_valid), 32'd0);
        check("t5_faddr",     32'(fetch_addr),  32'd38);
        step(); step();
        check("t5_stay_halt", 32'(halted),     32'd1);
        check("t5_stay_addr", 32'(fetch_addr), 32'd38);
        redirect    = 1'b1;
        redirect_pc = 6'd0;
        step();
        redirect = 1'b0;
        check("t5_clear_halt", 32'(halted),     32'd0);
        check("t5_clear_addr", 32'(fetch_addr), 32'd0);

        // MVI in the last mapped word of the short program
        redirect2    = 1'b1;
        redirect_pc2 = 6'd10;
        step();
        redirect2 = 1'b0;
        check("t5s_redir_halt", 32'(halted2), 32'd0);
        step();
        check("t5s_imm_valid", 32'(instr_valid2), 32'd0);
        step();
        check("t5s_valid",  32'(instr_valid2), 32'd1);
        check("t5s_instr",  32'(instr2),       32'h4600);
        check("t5s_imm",    32'(imm2),         32'h0);
        check("t5s_ipc",    32'(instr_pc2),    32'd10);
        check("t5s_faddr",  32'(fetch_addr2),  32'd11);
        step();
        check("t5s_accept", 32'(instr_valid2), 32'd0);
        step();
        check("t5s_halted", 32'(halted2), 32'd1);

        // async reset in S_HOLD
        instr_ready = 1'b0;
        budget = 10;
        while (!instr_valid && budget > 0) begin
            step();
            budget--;
        end
        check("t6_in_hold", 32'(instr_valid), 32'd1);
        Resetn = 1'b0;
        #1;
        check("t6_rst_valid", 32'(instr_valid), 32'd0);
        check("t6_rst_faddr", 32'(fetch_addr),  32'd0);
        check("t6_rst_instr", 32'(instr),       32'h0);
        @(negedge Clock);
        Resetn      = 1'b1;
        instr_ready = 1'b1;
        step(); step();
        check("t6_re_instr", 32'(instr),       32'h4000);
        check("t6_re_imm",   32'(imm),         32'h0002);
        check("t6_re_valid", 32'(instr_valid), 32'd1);
        check("t6_re_ipc",   32'(instr_pc),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
